// File: rtl/mem_spi_multi_pkg.sv
// Shared definitions for the mem_spi_multi SPI memory controller:
// opcodes, FSM state type, dummy-cycle count and request-length decode.
package mem_spi_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_WRITE     = 8'h02;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  // Dummy SCLK cycles inserted between address and data on fast reads
  localparam int DUMMY_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Transfer length 1..4; 0 and anything above 4 mean a full word
  function automatic logic [2:0] norm_nbytes(input logic [2:0] nb);
    return ((nb == 3'd0) || (nb > 3'd4)) ? 3'd4 : nb;
  endfunction

endpackage

// File: rtl/mem_spi_multi_sclk_gen.sv
// SPI clock generator for mem_spi_multi. While enabled, sclk toggles every
// CLK_DIV clk cycles starting low; rise/fall strobes are high on the clk
// cycle whose edge makes sclk rise/fall. Disabled: counter cleared, sclk low.
module spi_sclk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_tick;

  assign w_tick     = i_en && (r_cnt == CW'(CLK_DIV - 1));
  assign o_rise_stb = w_tick && !r_sclk;
  assign o_fall_stb = w_tick && r_sclk;
  assign o_sclk     = r_sclk;

  // Half-period divider; held idle (low) whenever the frame is not running
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_tick) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_spi_multi.sv
// mem_spi_multi: SPI (mode 0) memory controller serving 1-4 byte reads and
// writes to NUM_CS devices behind one bus. Frame = opcode, address, data,
// all MSB first per byte, data bytes in little-endian order.
// Build option: define MEM_SPI_FAST_READ_EN to issue fast reads (0x0B with
// 8 dummy clocks before data); otherwise reads use 0x03.
module mem_spi_multi
  import mem_spi_pkg::*;
#(
  parameter  int NUM_CS     = 2,
  parameter  int ADDR_BYTES = 3,
  parameter  int CLK_DIV    = 1,
  localparam int CS_BITS    = (NUM_CS > 2) ? $clog2(NUM_CS) : 1,
  localparam int AW         = CS_BITS + 8 * ADDR_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  input  logic [2:0]        num_bytes,
  input  logic [AW-1:0]     target_address,
  input  logic              is_write,
  input  logic [31:0]       write_value,
  output logic [31:0]       fetched_value,
  input  logic              start_request,
  output logic              request_done,
  output logic              access_error,
  output logic              busy
);

  localparam int ABITS   = 8 * ADDR_BYTES;
  localparam int FRAME_W = 8 + ABITS + DUMMY_BITS + 32;
  localparam logic [CS_BITS:0] NUM_CS_V = (CS_BITS + 1)'(NUM_CS);

  state_t              r_state, w_next;
  logic [FRAME_W-1:0]  r_frame, w_frame;
  logic [31:0]         r_rx, r_fetched, w_data_le;
  logic [7:0]          r_bit_cnt, r_total, r_hdr;
  logic [7:0]          w_total, w_hdr, w_data_idx;
  logic                r_write, r_acc_err;
  logic [NUM_CS-1:0]   r_cs_n, w_cs_sel;
  logic [CS_BITS-1:0]  w_dev;
  logic [ABITS-1:0]    w_addr;
  logic [2:0]          w_nb;
  logic                w_dev_ok, w_sclk_en, w_rise, w_fall, w_last, w_in_data;
  logic                w_sclk;

  assign w_dev      = target_address[AW-1 -: CS_BITS];
  assign w_addr     = target_address[ABITS-1:0];
  assign w_nb       = norm_nbytes(num_bytes);
  assign w_dev_ok   = ({1'b0, w_dev} < NUM_CS_V);
  assign w_cs_sel   = NUM_CS'(1) << w_dev;
  assign w_data_le  = {write_value[7:0], write_value[15:8],
                       write_value[23:16], write_value[31:24]};
  assign w_total    = w_hdr + {2'b00, w_nb, 3'b000};
  assign w_last     = (r_bit_cnt == (r_total - 8'd1));
  assign w_data_idx = r_bit_cnt - r_hdr;
  assign w_in_data  = !r_write && (r_bit_cnt >= r_hdr);
  // Dropping start_request stops the clock on the very next edge (abort)
  assign w_sclk_en  = (r_state == ST_XFER) && start_request;

  assign sclk          = w_sclk;
  assign mosi          = r_frame[FRAME_W-1];
  assign cs_n          = r_cs_n;
  assign fetched_value = r_fetched;
  assign access_error  = r_acc_err;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (w_sclk_en),
    .o_sclk     (w_sclk),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall)
  );

  // Left-aligned outgoing frame and header length (bits before first data bit)
  always_comb begin
    w_frame = '0;
    w_hdr   = 8'(8 + ABITS);
`ifdef MEM_SPI_FAST_READ_EN
    if (is_write) begin
      w_frame = {OP_WRITE, w_addr, w_data_le, 8'h00};
    end else begin
      w_frame = {OP_FAST_READ, w_addr, 8'h00, 32'h0};
      w_hdr   = 8'(8 + ABITS + DUMMY_BITS);
    end
`else
    w_frame = {(is_write ? OP_WRITE : OP_READ), w_addr,
               (is_write ? w_data_le : 32'h0), 8'h00};
`endif
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start_request) w_next = w_dev_ok ? ST_XFER : ST_DONE;
      ST_XFER: begin
        if (!start_request)      w_next = ST_IDLE;
        else if (w_fall && w_last) w_next = ST_DONE;
      end
      ST_DONE: if (!start_request) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy         = (r_state == ST_XFER);
    request_done = (r_state == ST_DONE) && start_request;
  end

  // Frame control: latch request, shift mosi on sclk fall, close the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_n    <= '1;
      r_frame   <= '0;
      r_fetched <= '0;
      r_acc_err <= 1'b0;
      r_write   <= 1'b0;
      r_total   <= '0;
      r_hdr     <= '0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_request) begin
            if (w_dev_ok) begin
              r_cs_n    <= ~w_cs_sel;
              r_frame   <= w_frame;
              r_write   <= is_write;
              r_total   <= w_total;
              r_hdr     <= w_hdr;
              r_bit_cnt <= '0;
            end else begin
              r_acc_err <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          if (!start_request) begin
            r_cs_n  <= '1;
            r_frame <= '0;
          end else if (w_fall) begin
            if (w_last) begin
              r_cs_n  <= '1;
              r_frame <= '0;
              if (!r_write) r_fetched <= r_rx;
            end else begin
              r_frame   <= r_frame << 1;
              r_bit_cnt <= r_bit_cnt + 8'd1;
            end
          end
        end
        ST_DONE: begin
          if (!start_request) r_acc_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Read assembly: data bit j lands in byte j/8, bit 7-(j%8), i.e. index j^7
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE)
      r_rx <= '0;
    else if (w_rise && w_in_data)
      r_rx[w_data_idx[4:0] ^ 5'd7] <= miso;
  end

endmodule

// File: tb/tb_mem_spi_multi.sv
// Self-checking bench for mem_spi_multi: directed and random transfers
// compared against a byte-level frame model and an SPI slave model.
`timescale 1ns/1ps
module tb_mem_spi_multi;

  localparam int NCS = 3;
  localparam int AB  = 3;
  localparam int CD  = 2;
  localparam int CSB = 2;
  localparam int AW  = CSB + 8 * AB;

  logic            clk = 1'b0;
  logic            rst, miso, sclk, mosi;
  logic [NCS-1:0]  cs_n;
  logic [2:0]      num_bytes;
  logic [AW-1:0]   target_address;
  logic            is_write;
  logic [31:0]     write_value, fetched_value;
  logic            start_request, request_done, access_error, busy;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_fetched;

  always #5 clk = ~clk;

  mem_spi_multi #(.NUM_CS(NCS), .ADDR_BYTES(AB), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .num_bytes(num_bytes), .target_address(target_address), .is_write(is_write),
    .write_value(write_value), .fetched_value(fetched_value),
    .start_request(start_request), .request_done(request_done),
    .access_error(access_error), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".cs_n"}, 128'(cs_n), 128'({NCS{1'b1}}));
    check_eq({tag, ".sclk"}, 128'(sclk), 128'(0));
    check_eq({tag, ".busy"}, 128'(busy), 128'(0));
    check_eq({tag, ".fetched"}, 128'(fetched_value), 128'(exp_fetched));
  endtask

  // mode 0: full transfer; 1: abort after 20 sclk edges; 2: async reset mid-frame
  task automatic do_xfer(input int dev, input logic [8*AB-1:0] addr, input bit wr,
                         input int nb_raw, input logic [31:0] wv, input logic [31:0] resp,
                         input int mode, input string tag);
    int nb, hdr, total, cyc, rises, edges, run, cs_cycles, bad_cs, bad_run, bad_busy;
    logic [127:0] exp_mosi, cap, miso_vec;
    logic [7:0] op;
    logic [NCS-1:0] mask;
    logic [31:0] bmask;
    logic prev_sclk;
    bit done;
    nb = (nb_raw >= 1 && nb_raw <= 4) ? nb_raw : 4;
`ifdef MEM_SPI_FAST_READ_EN
    op  = wr ? 8'h02 : 8'h0B;
    hdr = 8 + 8 * AB + (wr ? 0 : 8);
`else
    op  = wr ? 8'h02 : 8'h03;
    hdr = 8 + 8 * AB;
`endif
    total = hdr + 8 * nb;
    exp_mosi = '0;
    miso_vec = '0;
    for (int i = 0; i < 8; i++) exp_mosi[i] = op[7-i];
    for (int i = 0; i < 8 * AB; i++) exp_mosi[8+i] = addr[8*AB-1-i];
    for (int i = 0; i < hdr; i++) miso_vec[i] = 1'($urandom);
    for (int k = 0; k < nb; k++)
      for (int i = 0; i < 8; i++) begin
        if (wr) exp_mosi[hdr+8*k+i] = wv[8*k+7-i];
        miso_vec[hdr+8*k+i] = resp[8*k+7-i];
      end
    mask = ~(NCS'(1) << dev);

    num_bytes      = 3'(nb_raw);
    target_address = {CSB'(dev), addr};
    is_write       = wr;
    write_value    = wv;
    miso           = miso_vec[0];
    start_request  = 1'b1;

    cap = '0; rises = 0; edges = 0; run = 0; prev_sclk = 1'b0;
    cs_cycles = 0; bad_cs = 0; bad_run = 0; bad_busy = 0; cyc = 0; done = 0;
    while (!done && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (cs_n != {NCS{1'b1}}) begin
        cs_cycles++;
        if (cs_n != mask) bad_cs++;
        if (busy !== 1'b1) bad_busy++;
        if (sclk == prev_sclk) run++;
        else begin
          if (run != CD) bad_run++;
          run = 1;
        end
      end else if (busy !== 1'b0) bad_busy++;
      if (sclk !== prev_sclk) edges++;
      if (sclk && !prev_sclk) begin
        cap[rises] = mosi;
        rises++;
        miso = miso_vec[rises];
      end
      prev_sclk = sclk;
      if (request_done) done = 1;
      if (mode == 1 && edges == 20) break;
      if (mode == 2 && cyc == 15) break;
    end

    if (mode == 0) begin
      check_eq({tag, ".latency"}, 128'(cyc), 128'(1 + 2 * CD * total));
      check_eq({tag, ".pulses"}, 128'(rises), 128'(total));
      check_eq({tag, ".mosi"}, cap, exp_mosi);
      check_eq({tag, ".cs_cycles"}, 128'(cs_cycles), 128'(2 * CD * total));
      check_eq({tag, ".cs_sel"}, 128'(bad_cs), 128'(0));
      check_eq({tag, ".half_period"}, 128'(bad_run), 128'(0));
      check_eq({tag, ".busy_track"}, 128'(bad_busy), 128'(0));
      if (!wr) begin
        bmask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        exp_fetched = resp & bmask;
      end
      check_eq({tag, ".done"}, 128'(request_done), 128'(1));
      check_eq({tag, ".err"}, 128'(access_error), 128'(0));
      check_idle({tag, ".end"});
      start_request = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, ".done_clr"}, 128'(request_done), 128'(0));
      check_idle({tag, ".idle"});
    end else if (mode == 1) begin
      check_eq({tag, ".edges"}, 128'(edges), 128'(20));
      start_request = 1'b0;
      @(posedge clk); #1;
      check_idle({tag, ".abort"});
      check_eq({tag, ".done"}, 128'(request_done), 128'(0));
    end else begin
      check_eq({tag, ".pre_cs"}, 128'(cs_n), 128'(mask));
      #3 rst = 1'b1;
      #1;
      exp_fetched = '0;
      check_idle({tag, ".rst"});
      check_eq({tag, ".rst_mosi"}, 128'(mosi), 128'(0));
      check_eq({tag, ".rst_done"}, 128'(request_done), 128'(0));
      check_eq({tag, ".rst_err"}, 128'(access_error), 128'(0));
      start_request = 1'b0;
      #2 rst = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic bad_index(input string tag);
    num_bytes      = 3'd4;
    target_address = {2'd3, 24'h00_0100};
    is_write       = 1'b0;
    start_request  = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, ".done"}, 128'(request_done), 128'(1));
    check_eq({tag, ".err"}, 128'(access_error), 128'(1));
    for (int i = 0; i < 4; i++) begin
      check_idle({tag, ".quiet"});
      @(posedge clk); #1;
    end
    start_request = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, ".err_clr"}, 128'(access_error), 128'(0));
    check_eq({tag, ".done_clr"}, 128'(request_done), 128'(0));
  endtask

  initial begin
    rst = 1'b1; start_request = 1'b0; miso = 1'b0; num_bytes = '0;
    target_address = '0; is_write = 1'b0; write_value = '0; exp_fetched = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check_eq("reset.mosi", 128'(mosi), 128'(0));
    check_eq("reset.done", 128'(request_done), 128'(0));
    check_eq("reset.err", 128'(access_error), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    do_xfer(0, 24'h01_2345, 1'b0, 4, 32'h0, 32'h4433_2211, 0, "rd4");
    do_xfer(1, 24'hAB_CDEF, 1'b1, 2, 32'hAABB_CCDD, 32'h0, 0, "wr2");
    do_xfer(2, 24'h00_0010, 1'b0, 1, 32'h0, 32'h1234_565A, 0, "rd1");
    do_xfer(0, 24'h55_AA55, 1'b0, 0, 32'h0, 32'hCAFE_F00D, 0, "rd0as4");
    bad_index("badidx");
    do_xfer(1, 24'h77_0011, 1'b0, 4, 32'h0, 32'h0BAD_BEEF, 1, "abort");
    do_xfer(1, 24'h77_0011, 1'b0, 3, 32'h0, 32'h00C0_FFEE, 0, "after_abort");
    for (int t = 0; t < 8; t++) begin
      do_xfer($urandom_range(0, NCS - 1), (8*AB)'($urandom), bit'($urandom_range(0, 1)),
              $urandom_range(0, 7), $urandom, $urandom, 0, $sformatf("rnd%0d", t));
    end
    do_xfer(2, 24'h12_3456, 1'b0, 4, 32'h0, 32'h8765_4321, 2, "rstmid");
    do_xfer(0, 24'hFE_DCBA, 1'b0, 2, 32'h0, 32'h0000_A5C3, 0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
